// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_ctrl
// Description : Parses UART byte frames (AA addr data / BB addr) into
//               register-file writes and reads, returns read data to the
//               UART transmitter. Optional macro UART_CMD_WR_ACK_EN sends
//               an 8'h55 ACK after every successful write.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 1000,
    parameter int TO_WIDTH   = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_p_data,
    input  logic                  rx_data_valid,
    input  logic [DATA_WIDTH-1:0] rf_rd_data,
    input  logic                  rf_rd_valid,
    input  logic                  tx_busy,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    output logic                  rf_wr_en,
    output logic                  rf_rd_en,
    output logic [DATA_WIDTH-1:0] tx_p_data,
    output logic                  tx_data_valid,
    output logic                  cmd_error,
    output logic                  busy
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_WR_ADDR = 4'd1;
    localparam logic [3:0] S_WR_DATA = 4'd2;
    localparam logic [3:0] S_WR_EXEC = 4'd3;
    localparam logic [3:0] S_RD_ADDR = 4'd4;
    localparam logic [3:0] S_RD_REQ  = 4'd5;
    localparam logic [3:0] S_RD_WAIT = 4'd6;
    localparam logic [3:0] S_TX_WAIT = 4'd7;
    localparam logic [3:0] S_TX_SEND = 4'd8;

    localparam logic [DATA_WIDTH-1:0] c_op_wr   = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] c_op_rd   = DATA_WIDTH'(8'hBB);
    localparam logic [TO_WIDTH-1:0]   c_to_last = TO_WIDTH'(TIMEOUT - 1);
`ifdef UART_CMD_WR_ACK_EN
    localparam logic [DATA_WIDTH-1:0] c_ack     = DATA_WIDTH'(8'h55);
`endif

    logic [3:0]            r_state;
    logic [3:0]            w_next;
    logic [TO_WIDTH-1:0]   r_to_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_cmd_error;
    logic                  w_err;
    logic                  w_accept;
    logic                  w_timeout;
    logic                  w_addr_bad;
    logic                  w_counting;

    always_comb begin
        w_next     = r_state;
        w_err      = 1'b0;
        w_accept   = 1'b0;
        w_timeout  = (r_to_cnt == c_to_last);
        w_addr_bad = ((rx_p_data >> ADDR_WIDTH) != '0);
        case (r_state)
            S_IDLE: begin
                if (rx_data_valid) begin
                    if (rx_p_data == c_op_wr) begin
                        w_next   = S_WR_ADDR;
                        w_accept = 1'b1;
                    end else if (rx_p_data == c_op_rd) begin
                        w_next   = S_RD_ADDR;
                        w_accept = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            // An arriving byte takes priority over a same-cycle timeout.
            S_WR_ADDR, S_RD_ADDR: begin
                if (rx_data_valid) begin
                    w_accept = 1'b1;
                    if (w_addr_bad) begin
                        w_err  = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_next = (r_state == S_WR_ADDR) ? S_WR_DATA : S_RD_REQ;
                    end
                end else if (w_timeout) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_WR_DATA: begin
                if (rx_data_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_WR_EXEC;
                end else if (w_timeout) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_WR_EXEC: begin
                w_err = rx_data_valid;
`ifdef UART_CMD_WR_ACK_EN
                w_next = S_TX_WAIT;
`else
                w_next = S_IDLE;
`endif
            end
            S_RD_REQ: begin
                w_err  = rx_data_valid;
                w_next = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                w_err = rx_data_valid;
                if (rf_rd_valid) begin
                    w_next = S_TX_WAIT;
                end else if (w_timeout) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_TX_WAIT: begin
                w_err = rx_data_valid;
                if (!tx_busy) begin
                    w_next = S_TX_SEND;
                end
            end
            S_TX_SEND: begin
                w_err  = rx_data_valid;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_counting = (r_state == S_WR_ADDR) || (r_state == S_WR_DATA) ||
                        (r_state == S_RD_ADDR) || (r_state == S_RD_WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_to_cnt    <= '0;
            r_cmd_error <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cmd_error <= w_err;
            if ((w_next != r_state) || w_accept) begin
                r_to_cnt <= '0;
            end else if (w_counting) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr    <= '0;
            r_wr_data <= '0;
            r_tx_data <= '0;
        end else begin
            if (rx_data_valid && ((r_state == S_WR_ADDR) || (r_state == S_RD_ADDR))) begin
                r_addr <= rx_p_data[ADDR_WIDTH-1:0];
            end
            if (rx_data_valid && (r_state == S_WR_DATA)) begin
                r_wr_data <= rx_p_data;
            end
            if (rf_rd_valid && (r_state == S_RD_WAIT)) begin
                r_tx_data <= rf_rd_data;
            end
`ifdef UART_CMD_WR_ACK_EN
            if (r_state == S_WR_EXEC) begin
                r_tx_data <= c_ack;
            end
`endif
        end
    end

    assign rf_addr       = r_addr;
    assign rf_wr_data    = r_wr_data;
    assign tx_p_data     = r_tx_data;
    assign rf_wr_en      = (r_state == S_WR_EXEC);
    assign rf_rd_en      = (r_state == S_RD_REQ);
    assign tx_data_valid = (r_state == S_TX_SEND);
    assign cmd_error     = r_cmd_error;
    assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire
